token_buffer: RTL and testbench

- Responder side of the gating token-buffer interface: holds per-token partial sums and routing weights for the MoE aggregation path.
- Serves gating read requests (tbuf_rd_*) with fixed latency and absorbs gating writes (tbuf_wr_*).
- Secondary host port lets the main controller preload weights and drain final results.
- Built-in clear engine zeroes the array before a new token's aggregation.

---
 rtl/token_buffer.sv | 166 ++++++++++++++++
 tb/tb_token_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/token_buffer.sv
// Token buffer for the MoE aggregation path: a DEPTH x DW single-write/single-read array
// shared by the gating port, a host port and a built-in clear engine. Reads have 1-cycle latency.
module token_buffer #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int DW    = 64
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          tbuf_rd_en,
   input  logic [AW-1:0] tbuf_rd_addr,
   output logic [DW-1:0] tbuf_rd_data,
   output logic          tbuf_rd_valid,

   input  logic          tbuf_wr_en,
   input  logic [AW-1:0] tbuf_wr_addr,
   input  logic [DW-1:0] tbuf_wr_data,

   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,

   input  logic          clr_start,
   output logic          clr_busy,
   output logic          clr_done
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } clr_state_e;

   localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

   logic [DW-1:0] mem_q [DEPTH];

   clr_state_e    state_q;
   logic [AW-1:0] clr_cnt_q;
   logic          clr_busy_q;
   logic          clr_done_q;

   logic [DW-1:0] tbuf_rd_data_q;
   logic          tbuf_rd_valid_q;
   logic [DW-1:0] host_rdata_q;
   logic          host_rvalid_q;

   logic          host_rd_fire;
   logic          host_wr_fire;
   logic          clr_wr;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data_d;

   // Grants look only at current inputs and the busy flag so the host sees them in the same cycle.
   assign host_rd_fire = host_req && !host_we && !tbuf_rd_en && !clr_busy_q;
   assign host_wr_fire = host_req &&  host_we && !tbuf_wr_en && !clr_busy_q;
   assign host_gnt     = host_rd_fire || host_wr_fire;

   // A gating write steals the port from the clear engine, which then holds its counter.
   assign clr_wr = (state_q == S_CLEAR) && !tbuf_wr_en;

   // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (tbuf_wr_en) begin
         wr_en   = 1'b1;
         wr_addr = tbuf_wr_addr;
         wr_data = tbuf_wr_data;
      end else if (clr_wr) begin
         wr_en   = 1'b1;
         wr_addr = clr_cnt_q;
      end else if (host_wr_fire) begin
         wr_en   = 1'b1;
         wr_addr = host_addr;
         wr_data = host_wdata;
      end
   end

   always_comb begin
      rd_addr = tbuf_rd_en ? tbuf_rd_addr : host_addr;
      if (wr_en && (wr_addr == rd_addr)) begin
         rd_data_d = wr_data;
      end else begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   // NOTE: the array has no reset; clearing it is the job of the clear engine, not of rst_n.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbuf_rd_data_q  <= '0;
         tbuf_rd_valid_q <= 1'b0;
         host_rdata_q    <= '0;
         host_rvalid_q   <= 1'b0;
      end else begin
         tbuf_rd_valid_q <= tbuf_rd_en;
         host_rvalid_q   <= host_rd_fire;
         if (tbuf_rd_en) begin
            tbuf_rd_data_q <= rd_data_d;
         end
         if (host_rd_fire) begin
            host_rdata_q <= rd_data_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         clr_cnt_q  <= '0;
         clr_busy_q <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         clr_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (clr_start) begin
                  state_q    <= S_CLEAR;
                  clr_cnt_q  <= '0;
                  clr_busy_q <= 1'b1;
               end
            end
            S_CLEAR: begin
               if (clr_wr) begin
                  if (clr_cnt_q == CNT_LAST) begin
                     state_q    <= S_IDLE;
                     clr_busy_q <= 1'b0;
                     clr_done_q <= 1'b1;
                  end else begin
                     clr_cnt_q <= clr_cnt_q + AW'(1);
                  end
               end
            end
            default: begin
               state_q    <= S_IDLE;
               clr_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign tbuf_rd_data  = tbuf_rd_data_q;
   assign tbuf_rd_valid = tbuf_rd_valid_q;
   assign host_rdata    = host_rdata_q;
   assign host_rvalid   = host_rvalid_q;
   assign clr_busy      = clr_busy_q;
   assign clr_done      = clr_done_q;

endmodule

// File: tb/tb_token_buffer.sv
// Self-checking bench for token_buffer: table-driven port vectors with a read scoreboard,
// plus hand-written clear-with-stall and reset-mid-clear sequences.
module tb_token_buffer;

   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int DW    = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          tbuf_rd_en;
   logic [AW-1:0] tbuf_rd_addr;
   logic [DW-1:0] tbuf_rd_data;
   logic          tbuf_rd_valid;
   logic          tbuf_wr_en;
   logic [AW-1:0] tbuf_wr_addr;
   logic [DW-1:0] tbuf_wr_data;
   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_gnt;
   logic [DW-1:0] host_rdata;
   logic          host_rvalid;
   logic          clr_start;
   logic          clr_busy;
   logic          clr_done;

   always #5 clk = ~clk;

   token_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tbuf_rd_en   (tbuf_rd_en),
      .tbuf_rd_addr (tbuf_rd_addr),
      .tbuf_rd_data (tbuf_rd_data),
      .tbuf_rd_valid(tbuf_rd_valid),
      .tbuf_wr_en   (tbuf_wr_en),
      .tbuf_wr_addr (tbuf_wr_addr),
      .tbuf_wr_data (tbuf_wr_data),
      .host_req     (host_req),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_gnt     (host_gnt),
      .host_rdata   (host_rdata),
      .host_rvalid  (host_rvalid),
      .clr_start    (clr_start),
      .clr_busy     (clr_busy),
      .clr_done     (clr_done)
   );

   typedef struct {
      logic          rd_en;
      logic [AW-1:0] rd_addr;
      logic          wr_en;
      logic [AW-1:0] wr_addr;
      logic [DW-1:0] wr_data;
      logic          host_req;
      logic          host_we;
      logic [AW-1:0] host_addr;
      logic [DW-1:0] host_wdata;
      logic          exp_gnt;
   } vec_t;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] rd_q [$];
   logic [DW-1:0] host_q [$];
   logic [DW-1:0] last_rd   = '0;
   logic [DW-1:0] last_host = '0;
   vec_t          vecs [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      tbuf_rd_en   = 1'b0;
      tbuf_rd_addr = '0;
      tbuf_wr_en   = 1'b0;
      tbuf_wr_addr = '0;
      tbuf_wr_data = '0;
      host_req     = 1'b0;
      host_we      = 1'b0;
      host_addr    = '0;
      host_wdata   = '0;
      clr_start    = 1'b0;
   endtask

   function automatic vec_t mk(input logic rd_en, input logic [AW-1:0] rd_addr,
                               input logic wr_en, input logic [AW-1:0] wr_addr,
                               input logic [DW-1:0] wr_data, input logic hreq,
                               input logic hwe, input logic [AW-1:0] haddr,
                               input logic [DW-1:0] hwdata, input logic exp_gnt);
      vec_t v;
      v.rd_en = rd_en;     v.rd_addr = rd_addr;
      v.wr_en = wr_en;     v.wr_addr = wr_addr;   v.wr_data = wr_data;
      v.host_req = hreq;   v.host_we = hwe;       v.host_addr = haddr;
      v.host_wdata = hwdata;
      v.exp_gnt = exp_gnt;
      return v;
   endfunction

   // One clock of stimulus: check the combinational grant, update the model, queue expected
   // read data, then compare valids and data (data must hold when valid is low).
   task automatic run_vec(input vec_t v, input string tag);
      logic exp_rv;
      logic exp_hv;
      tbuf_rd_en   = v.rd_en;    tbuf_rd_addr = v.rd_addr;
      tbuf_wr_en   = v.wr_en;    tbuf_wr_addr = v.wr_addr;  tbuf_wr_data = v.wr_data;
      host_req     = v.host_req; host_we      = v.host_we;
      host_addr    = v.host_addr; host_wdata  = v.host_wdata;
      clr_start    = 1'b0;
      #1;
      check({tag, " host_gnt"}, 64'(host_gnt), 64'(v.exp_gnt));
      if (v.wr_en) model_mem[v.wr_addr] = v.wr_data;
      else if (v.host_req && v.host_we && v.exp_gnt) model_mem[v.host_addr] = v.host_wdata;
      exp_rv = v.rd_en;
      exp_hv = v.host_req && !v.host_we && v.exp_gnt;
      if (exp_rv) rd_q.push_back(model_mem[v.rd_addr]);
      if (exp_hv) host_q.push_back(model_mem[v.host_addr]);
      step();
      check({tag, " tbuf_rd_valid"}, 64'(tbuf_rd_valid), 64'(exp_rv));
      check({tag, " host_rvalid"}, 64'(host_rvalid), 64'(exp_hv));
      if (exp_rv && rd_q.size() > 0) last_rd = rd_q.pop_front();
      if (exp_hv && host_q.size() > 0) last_host = host_q.pop_front();
      check({tag, " tbuf_rd_data"}, tbuf_rd_data, last_rd);
      check({tag, " host_rdata"}, host_rdata, last_host);
   endtask

   initial begin
      int   busy_cycles;
      int   done_cnt;
      logic ended;

      idle_inputs();
      rst_n = 1'b0;
      #3;
      check("reset tbuf_rd_valid", 64'(tbuf_rd_valid), 64'(0));
      check("reset host_rvalid", 64'(host_rvalid), 64'(0));
      check("reset clr_busy", 64'(clr_busy), 64'(0));
      check("reset clr_done", 64'(clr_done), 64'(0));
      check("reset tbuf_rd_data", tbuf_rd_data, 64'(0));
      check("reset host_rdata", host_rdata, 64'(0));
      #9 rst_n = 1'b1;
      step();

      // ---------------- table-driven port vectors ----------------
      vecs.push_back(mk(0, 8'h00, 1, 8'h05, 64'h0123_4567_89AB_CDEF, 0, 0, 8'h00, '0, 0));
      vecs.push_back(mk(1, 8'h05, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 8'h10, 64'h1111_2222_3333_4444, 0, 0, 8'h00, '0, 0));
      vecs.push_back(mk(1, 8'h10, 1, 8'h10, 64'hDEAD_BEEF_0000_0001, 0, 0, 8'h00, '0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 8'h20, 64'hA5A5_0000_5A5A_0020, 0, 0, 8'h00, '0, 0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(1, 8'h05, 0, 8'h00, '0, 1, 0, 8'h20, '0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 8'h00, '0, 1, 0, 8'h20, '0, 1));
      vecs.push_back(mk(1, 8'h20, 0, 8'h00, '0, 1, 1, 8'h30, 64'hC0FF_EE00_0000_0030, 1));
      vecs.push_back(mk(1, 8'h30, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 8'h32, 64'h3232_3232_3232_3232, 1, 1, 8'h31,
                        64'h3131_3131_3131_3131, 0));
      vecs.push_back(mk(0, 8'h00, 0, 8'h00, '0, 1, 1, 8'h31, 64'h3131_3131_3131_3131, 1));
      vecs.push_back(mk(1, 8'h40, 0, 8'h00, '0, 1, 1, 8'h40, 64'h4040_0000_0000_4040, 1));
      vecs.push_back(mk(0, 8'h00, 1, 8'h31, 64'h3131_FFFF_0000_3131, 1, 0, 8'h31, '0, 1));
      vecs.push_back(mk(0, 8'h00, 1, 8'hFF, 64'hFFFF_0000_FFFF_00FF, 0, 0, 8'h00, '0, 0));
      vecs.push_back(mk(1, 8'hFF, 0, 8'h00, '0, 1, 0, 8'h32, '0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 8'h00, '0, 1, 0, 8'h32, '0, 1));
      vecs.push_back(mk(0, 8'h00, 0, 8'h00, '0, 0, 0, 8'h00, '0, 0));
      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // ---------------- clear with gating-write stalls ----------------
      for (int a = 0; a < DEPTH; a++)
         run_vec(mk(0, 8'h00, 1, AW'(a), 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 8'h00, '0, 0),
                 $sformatf("fill%0d", a));
      idle_inputs();
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      check("clear busy after start", 64'(clr_busy), 64'(1));
      busy_cycles = 1;
      done_cnt    = 0;
      ended       = 1'b0;
      for (int i = 0; i < 400 && !ended; i++) begin
         idle_inputs();
         case (i)
            10:  begin tbuf_wr_en = 1; tbuf_wr_addr = 8'h03; tbuf_wr_data = 64'hD000_0000_0000_0003; end
            30:  clr_start = 1'b1;
            50:  begin tbuf_wr_en = 1; tbuf_wr_addr = 8'hE0; tbuf_wr_data = 64'hD100_0000_0000_00E0; end
            60:  begin tbuf_rd_en = 1; tbuf_rd_addr = 8'h01; end
            61:  begin tbuf_rd_en = 1; tbuf_rd_addr = 8'hFD; end
            70:  begin host_req = 1; host_we = 1; host_addr = 8'h50; host_wdata = 64'h5050; end
            100: begin tbuf_wr_en = 1; tbuf_wr_addr = 8'h20; tbuf_wr_data = 64'hD200_0000_0000_0020; end
            150: begin tbuf_wr_en = 1; tbuf_wr_addr = 8'hFE; tbuf_wr_data = 64'hD300_0000_0000_00FE; end
            default: ;
         endcase
         if (i == 70) begin
            #1;
            check("host write gnt during clear", 64'(host_gnt), 64'(0));
         end
         step();
         if (i == 60) check("clear rd cleared addr", tbuf_rd_data, 64'(0));
         if (i == 61) check("clear rd uncleared addr", tbuf_rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
         if (clr_done) done_cnt++;
         if (clr_busy) busy_cycles++;
         else begin
            ended = 1'b1;
            check("clr_done as busy falls", 64'(clr_done), 64'(1));
         end
      end
      check("clear completed within bound", 64'(ended), 64'(1));
      check("clear busy cycles with 4 stalls", 64'(busy_cycles), 64'(260));
      check("clear done pulses", 64'(done_cnt), 64'(1));
      idle_inputs();
      step();
      check("clr_done single cycle", 64'(clr_done), 64'(0));
      check("clr_busy stays low", 64'(clr_busy), 64'(0));

      for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
      model_mem[8'h03] = 64'hD000_0000_0000_0003;
      model_mem[8'h20] = 64'hD200_0000_0000_0020;
      for (int a = 0; a < DEPTH; a++)
         run_vec(mk(1, AW'(a), 0, 8'h00, '0, 0, 0, 8'h00, '0, 0), $sformatf("post_clear%0d", a));

      // ---------------- reset mid-clear ----------------
      idle_inputs();
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      for (int k = 0; k < 99; k++) step();
      tbuf_rd_en   = 1'b1;
      tbuf_rd_addr = 8'h03;
      step();
      check("pre-reset rd_valid", 64'(tbuf_rd_valid), 64'(1));
      check("pre-reset busy", 64'(clr_busy), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      check("async reset clr_busy", 64'(clr_busy), 64'(0));
      check("async reset clr_done", 64'(clr_done), 64'(0));
      check("async reset tbuf_rd_valid", 64'(tbuf_rd_valid), 64'(0));
      check("async reset host_rvalid", 64'(host_rvalid), 64'(0));
      check("async reset tbuf_rd_data", tbuf_rd_data, 64'(0));
      idle_inputs();
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      check("idle after reset release", 64'(clr_busy), 64'(0));
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      busy_cycles = 1;
      done_cnt    = 0;
      ended       = 1'b0;
      for (int i = 0; i < 400 && !ended; i++) begin
         step();
         if (clr_done) done_cnt++;
         if (clr_busy) busy_cycles++;
         else ended = 1'b1;
      end
      check("restart clear completed within bound", 64'(ended), 64'(1));
      check("restart clear busy cycles", 64'(busy_cycles), 64'(256));
      check("restart clear done pulses", 64'(done_cnt), 64'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
